yutorina_bus_arbiter_rr: RTL
============================

Name: yutorina_bus_arbiter_rr

Overview:
- Parametrised round-robin bus arbiter. It is the successor to the fixed 4-master arbiter.
- Serves NUM_MASTERS masters with active-low request/grant, and parks the grant on the last owner.
- Adds a tenure limit that forces rotation when other masters are waiting, plus a per-master lock that defeats that limit.
- Sits between the bus masters (CPU core, DMA, debug) and the bus address/data multiplexers, which select on the owner output.

Parameters:
- NUM_MASTERS, 4: number of masters; legal range 2..16.
- OWNER_W, 2: owner index width; must equal ceil(log2(NUM_MASTERS)).
- MAX_TENURE, 16: maximum contended hold cycles before a forced handoff; 0 disables the limit; legal range 0..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- req_  input  NUM_MASTERS  bus request, one bit per master, active-low.
- lock_  input  NUM_MASTERS  bus lock, one bit per master, active-low; meaningful only together with req_ of the same master.
- grnt_  output  NUM_MASTERS  bus grant, one bit per master, active-low; at most one bit low at any time.
- owner  output  OWNER_W  index of the current owner; drives the bus multiplexers.
- contended  output  1  high when the owner holds the bus while at least one other master requests.

Behaviour:
- Reset (rst high at a clk edge): owner=0, tenure=0, state=GRANT. Next cycle grnt_ = all ones except bit0 low; contended=0.
- grnt_[i] = low iff state==GRANT and owner==i. The decode is combinational from registers only; no input-to-output combinational path.
- others_req = any req_[j] low for j!=owner.
- contended = state==GRANT, req_[owner] low, and others_req.
- Keep condition, evaluated at each edge in GRANT: req_[owner] low AND (lock_[owner] low OR MAX_TENURE==0 OR tenure<MAX_TENURE OR !others_req). If true, owner is unchanged.
- Otherwise the next owner is the first requester found scanning owner+1, owner+2, ... with wrap modulo NUM_MASTERS. The scan excludes the current owner on a forced handoff (tenure expiry) and includes it last on a voluntary release.
- If no master requests, owner is unchanged (park). The parked owner keeps its grant, so a re-request by the parked master costs 0 cycles.
- Handoff latency: the new owner's grant appears 1 cycle after the edge at which the old owner released, or at which tenure expired.
- Tenure counter, 8 bits:
  - Cleared on reset and on every owner change.
  - Increments each cycle that contended is high.
  - Saturates at MAX_TENURE.
  - Held, not cleared, while uncontended.
- Lock: while both req_ and lock_ of the owner are low, no forced handoff occurs, regardless of tenure. The counter still saturates. Lock of a non-owner is ignored.
- Simultaneous release and new requests: the scan uses the request values sampled at that same edge.
- Reset mid-tenure or mid-lock: owner returns to 0 and the counter clears immediately at that edge.
- Index arithmetic: owner+k wraps modulo NUM_MASTERS, not modulo 2^OWNER_W. Owner values >= NUM_MASTERS must never occur.

Optional Feature:
- Macro YUTORINA_BUS_ARB_GAP_EN.
- Defined:
  - Every owner change passes through a one-cycle state GAP. In GAP, all grnt_ are high, contended=0, and owner already shows the new index.
  - GAP always returns to GRANT on the next edge. Requests seen in GAP are not re-arbitrated.
  - Handoff latency becomes 2 cycles. Park and keep add no gap.
- Undefined: state GAP does not exist; behaviour is as described above.

Test Plan:
- Reset, then all req_=1111 for 5 cycles -> grnt_=1110, owner=0, contended=0 throughout.
- req_[2] low from cycle 3, all others high -> grnt_=1011 and owner=2 at cycle 4; hold req_[2] for 40 cycles -> grant stays on 2, tenure stays 0.
- Masters 0 and 1 both request continuously, MAX_TENURE=16, owner 0 -> owner 0 gets 17 granted cycles, then owner=1 for 17 cycles, alternating with no idle cycle.
- Same as the previous scenario with lock_[0] low -> owner stays 0 for 100 cycles. Release lock_[0] at cycle 100 -> owner=1 at cycle 101.
- Owner 3 releases while masters 0 and 2 request on the same cycle -> next owner 0 (wrap past 3). Then 0 releases -> owner 2.
- With YUTORINA_BUS_ARB_GAP_EN, owner 0 releases at cycle 10 with master 1 requesting -> grnt_=1111 and owner=1 at cycle 11; grnt_=1101 at cycle 12. Assert rst at cycle 11 -> grnt_=1110 at cycle 12.

Source files
------------

// File: rtl/yutorina_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// yutorina_bus_arbiter_rr : round-robin arbiter, active-low req/grant, parking,
// tenure limit with lock override. Optional YUTORINA_BUS_ARB_GAP_EN adds an
// idle GAP cycle on every owner change.                           Rev 1.0
// ============================================================================
module yutorina_bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = 2,
  parameter int MAX_TENURE  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req_,
  input  logic [NUM_MASTERS-1:0] lock_,
  output logic [NUM_MASTERS-1:0] grnt_,
  output logic [OWNER_W-1:0]     owner,
  output logic                   contended
);

  localparam logic [7:0] c_max_tenure = 8'(MAX_TENURE);
  localparam logic       c_no_limit   = (MAX_TENURE == 0);

  logic [OWNER_W-1:0]     r_owner;
  logic [7:0]             r_tenure;
  logic [NUM_MASTERS-1:0] w_own_onehot;
  logic                   w_in_grant;
  logic                   w_others_req;
  logic                   w_keep;
  logic                   w_found;
  logic [OWNER_W-1:0]     w_next_owner;

`ifdef YUTORINA_BUS_ARB_GAP_EN
  typedef enum logic [0:0] {
    ST_GRANT = 1'b0,
    ST_GAP   = 1'b1
  } state_t;

  state_t r_state;

  assign w_in_grant = (r_state == ST_GRANT);
`else
  assign w_in_grant = 1'b1;
`endif

  assign w_own_onehot = NUM_MASTERS'(1) << r_owner;
  assign w_others_req = |(~req_ & ~w_own_onehot);

  // Grant and owner are decoded purely from registers.
  assign grnt_     = w_in_grant ? ~w_own_onehot : '1;
  assign owner     = r_owner;
  assign contended = w_in_grant & ~req_[r_owner] & w_others_req;

  assign w_keep = ~req_[r_owner] &
                  (~lock_[r_owner] | c_no_limit |
                   (r_tenure < c_max_tenure) | ~w_others_req);

  // Scan owner+1 .. owner+N-1 modulo NUM_MASTERS; the owner itself never wins
  // a scan because it only reaches here when releasing or being forced off.
  always_comb begin
    int                 idx;
    logic [OWNER_W-1:0] cand;
    w_found      = 1'b0;
    w_next_owner = r_owner;
    idx          = 0;
    cand         = '0;
    for (int k = 1; k < NUM_MASTERS; k++) begin
      idx = int'(r_owner) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      cand = OWNER_W'(idx);
      if (!w_found && !req_[cand]) begin
        w_found      = 1'b1;
        w_next_owner = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner  <= '0;
      r_tenure <= '0;
`ifdef YUTORINA_BUS_ARB_GAP_EN
      r_state  <= ST_GRANT;
`endif
    end else begin
`ifdef YUTORINA_BUS_ARB_GAP_EN
      if (r_state == ST_GAP) begin
        r_state <= ST_GRANT;
      end else
`endif
      if (w_keep) begin
        if (contended && (r_tenure < c_max_tenure))
          r_tenure <= r_tenure + 8'd1;
      end else if (w_found) begin
        r_owner  <= w_next_owner;
        r_tenure <= '0;
`ifdef YUTORINA_BUS_ARB_GAP_EN
        r_state  <= ST_GAP;
`endif
      end
    end
  end

endmodule
`default_nettype wire
